// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared memory geometry constants for the RAM arbiter
package ram_arbiter_pkg;

  localparam int MEMORY_DATA_WIDTH    = 32;
  localparam int MEMORY_DEPTH         = 256;
  localparam int MEMORY_ADDRESS_WIDTH = $clog2(MEMORY_DEPTH);
  localparam int NUM_MEMORY_PORTS     = 2;

endpackage

// File: rtl/ram_arbiter_round_robin.sv
// rtl/ram_arbiter_round_robin.sv - round-robin grant selection with rotating priority pointer
module round_robin_arbiter #(
  parameter int NumPorts = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NumPorts-1:0] i_eligible,
  input  logic                i_advance,
  output logic [NumPorts-1:0] o_grant
);

  localparam int PtrWidth = $clog2(NumPorts);
  localparam int IdxWidth = PtrWidth + 1;

  logic [PtrWidth-1:0] pointer;
  logic [PtrWidth-1:0] grant_index;
  logic [IdxWidth-1:0] search_index;
  logic [IdxWidth-1:0] next_index;
  logic                found;

  // Search from the pointer upward, wrapping, and take the first eligible port.
  always_comb begin
    o_grant      = '0;
    grant_index  = '0;
    search_index = '0;
    found        = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      search_index = {1'b0, pointer} + IdxWidth'(i);
      if (search_index >= IdxWidth'(NumPorts)) begin
        search_index = search_index - IdxWidth'(NumPorts);
      end
      if (!found && i_eligible[search_index[PtrWidth-1:0]]) begin
        found       = 1'b1;
        grant_index = search_index[PtrWidth-1:0];
      end
    end
    if (found) begin
      o_grant[grant_index] = 1'b1;
    end
    next_index = {1'b0, grant_index} + IdxWidth'(1);
    if (next_index == IdxWidth'(NumPorts)) begin
      next_index = '0;
    end
  end

  // Move priority to the port after the winner; hold when nothing was granted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pointer <= '0;
    end else if (i_advance && found) begin
      pointer <= next_index[PtrWidth-1:0];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port RAM between several requesters
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DataWidth    = MEMORY_DATA_WIDTH,
  parameter int Depth        = MEMORY_DEPTH,
  parameter int AddressWidth = MEMORY_ADDRESS_WIDTH,
  parameter int NumPorts     = NUM_MEMORY_PORTS
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic [NumPorts-1:0]                  i_req_valid,
  output logic [NumPorts-1:0]                  o_req_ready,
  input  logic [NumPorts-1:0]                  i_req_write,
  input  logic [NumPorts-1:0][AddressWidth-1:0] i_req_address,
  input  logic [NumPorts-1:0][DataWidth-1:0]   i_req_write_data,
  output logic [NumPorts-1:0]                  o_rsp_valid,
  input  logic [NumPorts-1:0]                  i_rsp_ready,
  output logic [NumPorts-1:0][DataWidth-1:0]   o_rsp_read_data,
  output logic                                 o_ram_enable,
  output logic                                 o_ram_write_enable,
  output logic [AddressWidth-1:0]              o_ram_address,
  output logic [DataWidth-1:0]                 o_ram_write_data,
  input  logic [DataWidth-1:0]                 i_ram_read_data
);

  localparam int PtrWidth = $clog2(NumPorts);
  localparam logic [AddressWidth:0] DepthLimit = (AddressWidth + 1)'(Depth);

  logic [NumPorts-1:0]     eligible;
  logic [NumPorts-1:0]     grant;
  logic                    has_grant;
  logic [PtrWidth-1:0]     sel;
  logic [AddressWidth-1:0] sel_address;
  logic                    in_range;

  // A port competes only when its response slot is free or being drained now.
  always_comb begin
    eligible = i_req_valid & (~o_rsp_valid | i_rsp_ready) & {NumPorts{!i_reset}};
  end

  round_robin_arbiter #(
    .NumPorts(NumPorts)
  ) u_round_robin_arbiter (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_eligible(eligible),
    .i_advance (has_grant),
    .o_grant   (grant)
  );

  // Steer the granted port's command onto the RAM; out-of-range accesses never enable it.
  always_comb begin
    sel = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (grant[p]) begin
        sel = PtrWidth'(p);
      end
    end
    has_grant          = |grant;
    sel_address        = i_req_address[sel];
    in_range           = has_grant && ({1'b0, sel_address} < DepthLimit);
    o_req_ready        = grant;
    o_ram_enable       = in_range;
    o_ram_write_enable = in_range && i_req_write[sel];
    o_ram_address      = has_grant ? sel_address : '0;
    o_ram_write_data   = has_grant ? i_req_write_data[sel] : '0;
  end

  // Per-port response slot: set on grant, cleared on consume, data held until the next grant.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rsp_valid     <= '0;
      o_rsp_read_data <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (grant[p]) begin
          o_rsp_valid[p]     <= 1'b1;
          o_rsp_read_data[p] <= in_range ? i_ram_read_data : '0;
        end else if (i_rsp_ready[p]) begin
          o_rsp_valid[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_write;
  logic [1:0][7:0]   req_address;
  logic [1:0][31:0]  req_write_data;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [1:0][31:0]  rsp_read_data;
  logic              ram_enable;
  logic              ram_write_enable;
  logic [7:0]        ram_address;
  logic [31:0]       ram_write_data;
  logic [31:0]       ram_read_data;

  logic [31:0]       mem [0:255];
  logic              preload_en;
  logic [7:0]        preload_addr;
  logic [31:0]       preload_data;

  int checks;
  int errors;

  ram_arbiter #(
    .DataWidth   (32),
    .Depth       (200),
    .AddressWidth(8),
    .NumPorts    (2)
  ) dut (
    .i_clock           (clk),
    .i_reset           (reset),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_write       (req_write),
    .i_req_address     (req_address),
    .i_req_write_data  (req_write_data),
    .o_rsp_valid       (rsp_valid),
    .i_rsp_ready       (rsp_ready),
    .o_rsp_read_data   (rsp_read_data),
    .o_ram_enable      (ram_enable),
    .o_ram_write_enable(ram_write_enable),
    .o_ram_address     (ram_address),
    .o_ram_write_data  (ram_write_data),
    .i_ram_read_data   (ram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_read_data = mem[ram_address];

  always @(posedge clk) begin
    if (preload_en) begin
      mem[preload_addr] <= preload_data;
    end else if (ram_enable && ram_write_enable) begin
      mem[ram_address] <= ram_write_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [31:0] data);
    preload_addr = addr;
    preload_data = data;
    preload_en   = 1'b1;
    step();
    preload_en   = 1'b0;
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] write,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] rready);
    req_valid         = valid;
    req_write         = write;
    req_address[0]    = a0;
    req_address[1]    = a1;
    req_write_data[0] = d0;
    req_write_data[1] = d1;
    rsp_ready         = rready;
    #1;
  endtask

  logic [1:0] exp_grant;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    preload_en = 1'b0;
    preload_addr = '0;
    preload_data = '0;
    req_valid = '0;
    req_write = '0;
    req_address = '0;
    req_write_data = '0;
    rsp_ready = '0;
    step();

    preload(8'h01, 32'h0000_1111);
    preload(8'h02, 32'h0000_2222);
    preload(8'h05, 32'h0000_0001);
    preload(8'h10, 32'h0000_0000);
    preload(8'h20, 32'h0000_A0A0);
    preload(8'h21, 32'h0000_B1B1);
    preload(8'd250, 32'h0000_7777);

    // Reset with both ports requesting writes
    drive(2'b11, 2'b11, 8'h01, 8'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_ram_en", 64'(ram_enable), 64'h0);
    check("rst_ram_we", 64'(ram_write_enable), 64'h0);
    step();
    step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data", 64'(rsp_read_data), 64'h0);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00);
    reset = 1'b0;
    step();
    check("rst_mem1", 64'(mem[1]), 64'h1111);
    check("rst_mem2", 64'(mem[2]), 64'h2222);
    check("idle_ram_en", 64'(ram_enable), 64'h0);

    // Single write on port 1, then read it back
    drive(2'b10, 2'b10, 8'h00, 8'h10, 32'h0, 32'hDEAD_BEEF, 2'b00);
    check("wr_ready", 64'(req_ready), 64'h2);
    check("wr_ram_en", 64'(ram_enable), 64'h1);
    check("wr_ram_we", 64'(ram_write_enable), 64'h1);
    check("wr_ram_addr", 64'(ram_address), 64'h10);
    step();
    check("wr_rsp_valid", 64'(rsp_valid), 64'h2);
    check("wr_rsp_old", 64'(rsp_read_data[1]), 64'h0);
    check("wr_mem", 64'(mem[8'h10]), 64'hDEAD_BEEF);
    drive(2'b10, 2'b00, 8'h00, 8'h10, 32'h0, 32'h0, 2'b10);
    check("rd_ready", 64'(req_ready), 64'h2);
    check("rd_ram_we", 64'(ram_write_enable), 64'h0);
    step();
    check("rd_rsp_valid", 64'(rsp_valid), 64'h2);
    check("rd_rsp_data", 64'(rsp_read_data[1]), 64'hDEAD_BEEF);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b11);
    step();
    check("drain_valid", 64'(rsp_valid), 64'h0);

    // Contention: both ports read continuously and consume every response
    exp_grant = 2'b01;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 8'h20, 8'h21, 32'h0, 32'h0, 2'b11);
      check("rr_grant", 64'(req_ready), 64'(exp_grant));
      step();
      check("rr_rsp_valid", 64'(rsp_valid), 64'(exp_grant));
      if (exp_grant == 2'b01) begin
        check("rr_data0", 64'(rsp_read_data[0]), 64'hA0A0);
      end else begin
        check("rr_data1", 64'(rsp_read_data[1]), 64'hB1B1);
      end
      exp_grant = ~exp_grant;
    end

    // Backpressure: port 0 withholds consumption
    drive(2'b11, 2'b00, 8'h20, 8'h21, 32'h0, 32'h0, 2'b10);
    check("bp_first", 64'(req_ready), 64'h1);
    step();
    check("bp_valid0", 64'(rsp_valid), 64'h1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 8'h20, 8'h21, 32'h0, 32'h0, 2'b10);
      check("bp_skip0", 64'(req_ready), 64'h2);
      step();
      check("bp_held_valid", 64'(rsp_valid), 64'h3);
      check("bp_held_data", 64'(rsp_read_data[0]), 64'hA0A0);
    end
    drive(2'b11, 2'b00, 8'h20, 8'h21, 32'h0, 32'h0, 2'b11);
    check("bp_release", 64'(req_ready), 64'h1);
    step();
    check("bp_rel_valid", 64'(rsp_valid), 64'h1);

    // Read-before-write acknowledgement on address 5
    drive(2'b01, 2'b01, 8'h05, 8'h00, 32'h2, 32'h0, 2'b11);
    check("rbw_ready", 64'(req_ready), 64'h1);
    step();
    check("rbw_old", 64'(rsp_read_data[0]), 64'h1);
    drive(2'b01, 2'b00, 8'h05, 8'h00, 32'h0, 32'h0, 2'b11);
    step();
    check("rbw_new", 64'(rsp_read_data[0]), 64'h2);

    // Out-of-range read (Depth = 200)
    drive(2'b01, 2'b00, 8'd210, 8'h00, 32'h0, 32'h0, 2'b11);
    check("oor_ready", 64'(req_ready), 64'h1);
    check("oor_ram_en", 64'(ram_enable), 64'h0);
    check("oor_ram_addr", 64'(ram_address), 64'd210);
    step();
    check("oor_valid", 64'(rsp_valid), 64'h1);
    check("oor_data", 64'(rsp_read_data[0]), 64'h0);

    // Out-of-range write must not touch memory
    drive(2'b10, 2'b10, 8'h00, 8'd250, 32'h0, 32'h5555, 2'b11);
    check("oorw_ready", 64'(req_ready), 64'h2);
    check("oorw_ram_we", 64'(ram_write_enable), 64'h0);
    step();
    check("oorw_data", 64'(rsp_read_data[1]), 64'h0);
    check("oorw_mem", 64'(mem[250]), 64'h7777);

    // Deasserted request: no grant, no RAM activity
    drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b11);
    check("none_ready", 64'(req_ready), 64'h0);
    check("none_addr", 64'(ram_address), 64'h0);
    step();
    check("none_valid", 64'(rsp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
